four_one_mux: RTL and testbench

- Registered 4:1 multiplexer for WIDTH-bit data words.
- Built structurally as a tree of three 2:1 muxes.
- Stage 1: a/b and c/d, selected by s[0]. Stage 2: the two stage-1 results, selected by s[1].
- Tree output is captured in an output register. Used as a generic word-select primitive in datapaths.

---
 rtl/four_one_mux_pkg.sv | 10 +
 rtl/four_one_mux_two_one_mux.sv | 14 +
 rtl/four_one_mux.sv | 51 +++++
 tb/tb_four_one_mux.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/four_one_mux_pkg.sv
// Shared constants for the word-select mux primitives.
// Select codes are kept here so benches and datapaths agree on them.
package four_one_mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/four_one_mux_two_one_mux.sv
// Combinational 2:1 word mux.
// Leaf cell of the four_one_mux select tree.
module two_one_mux #(
    parameter int WIDTH = 4
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/four_one_mux.sv
// Registered 4:1 word mux built from a tree of three 2:1 muxes.
// s[0] picks odd over even inputs, s[1] picks the upper pair.
module four_one_mux
    import four_one_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] sel;

    two_one_mux #(.WIDTH(WIDTH)) u_lo (
        .sel (s[0]),
        .in0 (a),
        .in1 (b),
        .out (lo)
    );

    two_one_mux #(.WIDTH(WIDTH)) u_hi (
        .sel (s[0]),
        .in0 (c),
        .in1 (d),
        .out (hi)
    );

    two_one_mux #(.WIDTH(WIDTH)) u_top (
        .sel (s[1]),
        .in0 (lo),
        .in1 (hi),
        .out (sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= sel;
        end
    end

endmodule

// File: tb/tb_four_one_mux.sv
// Directed bench for four_one_mux.
// Inputs change on falling edges; dout is sampled 1ns after rising edges.
module tb_four_one_mux;
    import four_one_mux_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] dout;

    int n_cmp;
    int n_bad;

    four_one_mux #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic [1:0] ts,
                       input logic [3:0] ta,
                       input logic [3:0] tb,
                       input logic [3:0] tc,
                       input logic [3:0] td);
        s = ts;
        a = ta;
        b = tb;
        c = tc;
        d = td;
    endtask

    // Apply on falling edge, check after the following rising edge.
    task automatic step(input string tag,
                        input logic [1:0] ts,
                        input logic [3:0] ta,
                        input logic [3:0] tb,
                        input logic [3:0] tc,
                        input logic [3:0] td,
                        input logic [3:0] exp);
        @(negedge clk);
        put(ts, ta, tb, tc, td);
        @(posedge clk);
        #1;
        chk(tag, dout, exp);
    endtask

    logic [3:0] sweep_exp [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sweep_exp[0] = 4'd1;
        sweep_exp[1] = 4'd2;
        sweep_exp[2] = 4'd4;
        sweep_exp[3] = 4'd8;

        // Reset with a selected: dout held at zero
        put(SEL_A, 4'd1, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        #1;
        chk("rst_async", dout, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_held", dout, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", dout, 4'd0);
        @(posedge clk);
        #1;
        chk("first_cap", dout, 4'd1);

        step("sel_a", SEL_A, 4'd13, 4'd12, 4'd7, 4'd15, 4'd13);
        step("sel_c", SEL_C, 4'd5, 4'd3, 4'd14, 4'd6, 4'd14);
        step("sel_b_b2b", SEL_B, 4'd13, 4'd7, 4'd12, 4'd6, 4'd7);
        step("sel_d", SEL_D, 4'd5, 4'd12, 4'd6, 4'd6, 4'd6);
        step("sel_d_2", SEL_D, 4'd9, 4'd5, 4'd12, 4'd6, 4'd6);

        for (int i = 0; i < 4; i++) begin
            step($sformatf("sweep_%0d", i), 2'(i),
                 4'd1, 4'd2, 4'd4, 4'd8, sweep_exp[i]);
        end

        // Mid-stream reset between edges
        step("stream_c", SEL_C, 4'd0, 4'd0, 4'd14, 4'd0, 4'd14);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_async", dout, 4'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_held", dout, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_restore", dout, 4'd14);

        // Inputs toggled between edges must not reach dout
        @(negedge clk);
        put(SEL_B, 4'd3, 4'd9, 4'd10, 4'd11);
        #1;
        chk("stable_1", dout, 4'd14);
        #2;
        put(SEL_D, 4'd3, 4'd9, 4'd10, 4'd5);
        #1;
        chk("stable_2", dout, 4'd14);
        @(posedge clk);
        #1;
        chk("stable_cap", dout, 4'd5);
        #2;
        put(SEL_A, 4'd15, 4'd0, 4'd0, 4'd0);
        #1;
        chk("stable_3", dout, 4'd5);
        @(posedge clk);
        #1;
        chk("stable_cap2", dout, 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
